// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM time-base: default widths, count
// direction encodings, register-file bit positions and the per-cycle
// counter action encoding.
package pwm_pkg;

  // Default widths of the counter/period and the prescaler
  localparam int CNT_W_DEF = 16;
  localparam int PSC_W_DEF = 8;

  // Count direction as seen on upnotdown
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Functions-register encodings of the timer block
  localparam logic [1:0] FUNC_TIMEBASE = 2'b00;
  localparam logic [1:0] FUNC_CAPTURE  = 2'b01;
  localparam logic [1:0] FUNC_ONESHOT  = 2'b10;

  // Control-register bit positions
  localparam int CTRL_CNT_EN_BIT     = 0;
  localparam int CTRL_UPNOTDOWN_BIT  = 1;
  localparam int CTRL_FUNC_LSB       = 2;

  // What the counter does in a given cycle, in priority-resolved form
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,  // no tick: keep everything
    ACT_CLEAR   = 3'd1,  // cnt_reset strobe
    ACT_STOP    = 3'd2,  // disabled: hold count, shadow transparent
    ACT_INC     = 3'd3,  // up-count step
    ACT_DEC     = 3'd4,  // down-count step
    ACT_WRAP_UP = 3'd5,  // up-count reached period: wrap to 0
    ACT_WRAP_DN = 3'd6,  // down-count reached 0: reload period
    ACT_CLAMP   = 3'd7   // down-count above shrunk period: clamp
  } cnt_act_e;

endpackage

// File: rtl/pwm_counter_if.sv
// Configuration and status bundle between the register file (master)
// and the PWM time-base counter (slave).
interface pwm_counter_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
);

  logic             cnt_en;
  logic             cnt_reset;
  logic             upnotdown;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] count_val;
  logic [CNT_W-1:0] period_active;
  logic             overflow;
  logic             underflow;

  modport master (
    output cnt_en, cnt_reset, upnotdown, prescale, period,
    input  count_val, period_active, overflow, underflow
  );

  modport slave (
    input  cnt_en, cnt_reset, upnotdown, prescale, period,
    output count_val, period_active, overflow, underflow
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM time-base: issues one tick every
// prescale+1 enabled cycles. A smaller prescale written while the
// divider is already past it ticks at once instead of waiting for a
// 2^PSC_W rollover.
module pwm_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             clr,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  localparam logic [PSC_W-1:0] PSC_ZERO = {PSC_W{1'b0}};
  localparam logic [PSC_W-1:0] PSC_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [PSC_W-1:0] psc_cnt_r;
  logic [PSC_W-1:0] psc_cnt_nxt_s;
  logic             tick_s;

  // Tick detection and next divider value
  always_comb begin
    tick_s        = 1'b0;
    psc_cnt_nxt_s = psc_cnt_r;
    if (cnt_en && (psc_cnt_r >= prescale)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (!cnt_en || clr || tick_s) begin
      psc_cnt_nxt_s = PSC_ZERO;
    end else begin
      psc_cnt_nxt_s = psc_cnt_r + PSC_ONE;
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt_r <= PSC_ZERO;
    end else begin
      psc_cnt_r <= psc_cnt_nxt_s;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/pwm_counter.sv
// PWM time-base counter: prescaled up/down counter with a shadowed
// period that is only reloaded at wrap, on cnt_reset or while stopped.
// Overflow/underflow are one-cycle registered pulses aligned with the
// post-wrap count value.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_counter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             tick_s;
  cnt_act_e         act_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] period_act_r;
  logic             overflow_r;
  logic             underflow_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] period_act_nxt_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;

  pwm_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_en   (bus.cnt_en),
    .clr      (bus.cnt_reset),
    .prescale (bus.prescale),
    .tick     (tick_s)
  );

  // Resolve the cycle's action: clear beats stop beats tick beats hold
  always_comb begin
    act_s = ACT_HOLD;
    if (bus.cnt_reset) begin
      act_s = ACT_CLEAR;
    end else if (!bus.cnt_en) begin
      act_s = ACT_STOP;
    end else if (tick_s) begin
      if (bus.upnotdown == DIR_UP) begin
        if (count_r >= period_act_r) begin
          act_s = ACT_WRAP_UP;
        end else begin
          act_s = ACT_INC;
        end
      end else begin
        if (count_r == CNT_ZERO) begin
          act_s = ACT_WRAP_DN;
        end else if (count_r > period_act_r) begin
          act_s = ACT_CLAMP;
        end else begin
          act_s = ACT_DEC;
        end
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next count, shadow period and event pulses for the chosen action
  always_comb begin
    count_nxt_s      = count_r;
    period_act_nxt_s = period_act_r;
    overflow_nxt_s   = 1'b0;
    underflow_nxt_s  = 1'b0;
    case (act_s)
      ACT_CLEAR: begin
        count_nxt_s      = CNT_ZERO;
        period_act_nxt_s = bus.period;
      end
      ACT_STOP: begin
        period_act_nxt_s = bus.period;
      end
      ACT_INC: begin
        count_nxt_s = count_r + CNT_ONE;
      end
      ACT_DEC: begin
        count_nxt_s = count_r - CNT_ONE;
      end
      ACT_WRAP_UP: begin
        count_nxt_s      = CNT_ZERO;
        period_act_nxt_s = bus.period;
        overflow_nxt_s   = 1'b1;
      end
      ACT_WRAP_DN: begin
        // Reload from the new period so the shadow and count agree
        count_nxt_s      = bus.period;
        period_act_nxt_s = bus.period;
        underflow_nxt_s  = 1'b1;
      end
      ACT_CLAMP: begin
        count_nxt_s = period_act_r;
      end
      ACT_HOLD: begin
        count_nxt_s = count_r;
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Output and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= CNT_ZERO;
      period_act_r <= CNT_ZERO;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      period_act_r <= period_act_nxt_s;
      overflow_r   <= overflow_nxt_s;
      underflow_r  <= underflow_nxt_s;
    end
  end

  assign bus.count_val     = count_r;
  assign bus.period_active = period_act_r;
  assign bus.overflow      = overflow_r;
  assign bus.underflow     = underflow_r;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter: a table of one-cycle vectors with
// hand-computed outputs, plus an asynchronous-reset sequence.
module tb_pwm_counter;

  logic clk;
  logic rst_n;

  pwm_counter_if #(.CNT_W(16), .PSC_W(8)) bus_if ();

  pwm_counter #(.CNT_W(16), .PSC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic        en;
    logic        rs;
    logic        up;
    logic [7:0]  psc;
    logic [15:0] per;
    logic [15:0] cnt;
    logic [15:0] pa;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  task automatic add(input logic en, input logic rs, input logic up,
                     input int psc, input int per, input int cnt,
                     input int pa, input logic ovf, input logic unf);
    vec_t v;
    v.en  = en;
    v.rs  = rs;
    v.up  = up;
    v.psc = psc[7:0];
    v.per = per[15:0];
    v.cnt = cnt[15:0];
    v.pa  = pa[15:0];
    v.ovf = ovf;
    v.unf = unf;
    vecs.push_back(v);
  endtask

  function automatic logic [33:0] outs();
    return {bus_if.count_val, bus_if.period_active,
            bus_if.overflow, bus_if.underflow};
  endfunction

  task automatic check(input string name, input logic [33:0] got,
                       input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d pa=%0d ovf=%0b unf=%0b, want cnt=%0d pa=%0d ovf=%0b unf=%0b",
               name, got[33:18], got[17:2], got[1], got[0],
               exp[33:18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    bus_if.cnt_en    = 1'b0;
    bus_if.cnt_reset = 1'b0;
    bus_if.upnotdown = 1'b1;
    bus_if.prescale  = 8'd0;
    bus_if.period    = 16'd0;

    // Up count, prescale 0, period 4
    add(1, 1, 1, 0, 4, 0, 4, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 1, 0, 4, i, 4, 0, 0);
    add(1, 0, 1, 0, 4, 0, 4, 1, 0);
    add(1, 0, 1, 0, 4, 1, 4, 0, 0);
    // Prescale 2, period 3: one step every 3 clocks
    add(1, 1, 1, 2, 3, 0, 3, 0, 0);
    add(1, 0, 1, 2, 3, 0, 3, 0, 0);
    add(1, 0, 1, 2, 3, 0, 3, 0, 0);
    for (int v = 1; v <= 3; v++)
      for (int k = 0; k < 3; k++) add(1, 0, 1, 2, 3, v, 3, 0, 0);
    add(1, 0, 1, 2, 3, 0, 3, 1, 0);
    add(1, 0, 1, 2, 3, 0, 3, 0, 0);
    // Shadow: period 9, rewritten to 3 at count 5
    add(1, 1, 1, 0, 9, 0, 9, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, 1, 0, 9, i, 9, 0, 0);
    for (int i = 6; i <= 9; i++) add(1, 0, 1, 0, 3, i, 9, 0, 0);
    add(1, 0, 1, 0, 3, 0, 3, 1, 0);
    for (int i = 1; i <= 3; i++) add(1, 0, 1, 0, 3, i, 3, 0, 0);
    add(1, 0, 1, 0, 3, 0, 3, 1, 0);
    // Down count, period 5
    add(1, 1, 0, 0, 5, 0, 5, 0, 0);
    add(1, 0, 0, 0, 5, 5, 5, 0, 1);
    for (int i = 4; i >= 0; i--) add(1, 0, 0, 0, 5, i, 5, 0, 0);
    add(1, 0, 0, 0, 5, 5, 5, 0, 1);
    add(1, 0, 0, 0, 5, 4, 5, 0, 0);
    // Period 0: pulse every tick, count pinned at 0
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 2; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    // cnt_reset together with a tick, also at the wrap point
    add(1, 1, 1, 0, 4, 0, 4, 0, 0);
    add(1, 0, 1, 0, 4, 1, 4, 0, 0);
    add(1, 0, 1, 0, 4, 2, 4, 0, 0);
    add(1, 1, 1, 0, 4, 0, 4, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 1, 0, 4, i, 4, 0, 0);
    add(1, 1, 1, 0, 4, 0, 4, 0, 0);
    // Disable at 7 for 10 cycles, shadow follows period, resume at 8
    add(1, 1, 1, 0, 9, 0, 9, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 0, 1, 0, 9, i, 9, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 12, 7, 12, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 11, 7, 11, 0, 0);
    add(1, 0, 1, 0, 11, 8, 11, 0, 0);
    add(1, 0, 1, 0, 11, 9, 11, 0, 0);
    add(0, 1, 1, 0, 11, 0, 11, 0, 0);
    // Down count above a shrunk period clamps, then direction flips
    add(1, 1, 1, 0, 9, 0, 9, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 0, 1, 0, 9, i, 9, 0, 0);
    add(0, 0, 1, 0, 4, 7, 4, 0, 0);
    add(1, 0, 0, 0, 4, 4, 4, 0, 0);
    add(1, 0, 0, 0, 4, 3, 4, 0, 0);
    add(1, 0, 1, 0, 4, 4, 4, 0, 0);
    add(1, 0, 0, 0, 4, 3, 4, 0, 0);
    add(1, 0, 1, 0, 4, 4, 4, 0, 0);
    add(1, 0, 1, 0, 4, 0, 4, 1, 0);
    // Prescale shrunk below the running divider value ticks at once
    add(1, 1, 1, 3, 9, 0, 9, 0, 0);
    add(1, 0, 1, 3, 9, 0, 9, 0, 0);
    add(1, 0, 1, 3, 9, 0, 9, 0, 0);
    add(1, 0, 1, 1, 9, 1, 9, 0, 0);
    add(1, 0, 1, 1, 9, 1, 9, 0, 0);
    add(1, 0, 1, 1, 9, 2, 9, 0, 0);

    #1;
    check("reset_state", outs(), 34'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.cnt_en    = vecs[i].en;
      bus_if.cnt_reset = vecs[i].rs;
      bus_if.upnotdown = vecs[i].up;
      bus_if.prescale  = vecs[i].psc;
      bus_if.period    = vecs[i].per;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].cnt, vecs[i].pa, vecs[i].ovf, vecs[i].unf});
    end

    // Asynchronous reset in the middle of a run
    bus_if.prescale = 8'd0;
    @(posedge clk);
    #2;
    check("pre_async", outs(), {16'd3, 16'd9, 1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 34'd0);
    @(negedge clk);
    check("reset_held", outs(), 34'd0);
    rst_n            = 1'b1;
    bus_if.cnt_en    = 1'b0;
    bus_if.period    = 16'd6;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_stop", outs(), {16'd0, 16'd6, 1'b0, 1'b0});
    bus_if.cnt_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_1", outs(), {16'd1, 16'd6, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("post_rst_2", outs(), {16'd2, 16'd6, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
